// File: rtl/norm_pkg.sv
// Shared types, default widths and the selection-bit rule for the normalize engine.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package norm_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int          N_REQ_DEF = 4;
    localparam int          DW_DEF    = 32;
    localparam int          OW_DEF    = 16;
    localparam int          IXW       = 4;
    localparam int          SHW       = 6;
    localparam logic [15:0] LIMIT_DEF = 16'h8000;

    // Digit index 0..7 picks the odd bit 2*idx+1; any larger index falls back to bit 14.
    function automatic logic sel_bit(input logic [15:0] y, input logic [IXW-1:0] idx);
        logic b;
        if (idx > 4'd7) b = y[14];
        else            b = y[{idx[2:0], 1'b1}];
        return b;
    endfunction

endpackage

// File: rtl/norm_rr_arb.sv
// Round-robin request picker: first set request at or above ptr, wrapping mod N_REQ.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module norm_rr_arb
    import norm_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any_req,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDW-1:0]   win_id
);

    int cand;

    // Scan from the pointer upward and keep the first requester found.
    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win_id  = IDW'(cand);
            end
        end
        win_oh = any_req ? (N_REQ'(1) << win_id) : '0;
    end

endmodule

// File: rtl/norm_sched.sv
// Arbitrated normalize engine: shift a granted word right until below LIMIT, report result + selected bit.
// Latency: grant in cycle c, done_o in cycle c+2+k for k shifts (k <= DW-15); next grant >= 2 cycles after done.
// Backpressure: requesters hold req_i until their gnt_o pulse; requests wait while busy_o is high.
// Build option NORM_SCHED_FIXPRIO_EN: lowest-index-wins arbitration, pointer held at 0.
module norm_sched
    import norm_pkg::*;
#(
    parameter int             N_REQ = N_REQ_DEF,
    parameter int             DW    = DW_DEF,
    parameter int             OW    = OW_DEF,
    parameter logic [OW-1:0]  LIMIT = OW'(LIMIT_DEF)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DW-1:0]        data_i,
    input  logic [N_REQ*IXW-1:0]       index_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(N_REQ)-1:0]   done_id_o,
    output logic [OW-1:0]              y_o,
    output logic [SHW-1:0]             shift_o,
    output logic                       ytp_o
);

    localparam int IDW = $clog2(N_REQ);

    typedef struct packed {
        logic [OW-1:0]  y;
        logic [SHW-1:0] shift;
        logic           ytp;
        logic [IDW-1:0] id;
    } res_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_nxt;
    logic [IDW-1:0]   id_q;
    logic [N_REQ-1:0] gnt_q;
    logic [DW-1:0]    y_q;
    logic [IXW-1:0]   idx_q;
    logic [SHW-1:0]   cnt_q;
    res_t             res_q;

    logic             arb_any;
    logic [N_REQ-1:0] arb_oh;
    logic [IDW-1:0]   arb_id;
    logic             y_below;

    norm_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req     (req_i),
        .ptr     (ptr_q),
        .any_req (arb_any),
        .win_oh  (arb_oh),
        .win_id  (arb_id)
    );

    assign y_below = (y_q < DW'(LIMIT));

`ifdef NORM_SCHED_FIXPRIO_EN
    assign ptr_nxt = '0;
`else
    assign ptr_nxt = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`endif

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d = state_q;
        gnt_o   = '0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (arb_any) state_d = LOAD;
            end
            LOAD: begin
                gnt_o   = gnt_q;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (y_below) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Winner latch, operand capture, shift loop and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            id_q  <= '0;
            gnt_q <= '0;
            y_q   <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        id_q  <= arb_id;
                        gnt_q <= arb_oh;
                    end
                end
                LOAD: begin
                    y_q   <= data_i[int'(id_q)*DW +: DW];
                    idx_q <= index_i[int'(id_q)*IXW +: IXW];
                    cnt_q <= '0;
                    ptr_q <= ptr_nxt;
                end
                SHIFT: begin
                    if (y_below) begin
                        res_q.y     <= y_q[OW-1:0];
                        res_q.shift <= cnt_q;
                        res_q.ytp   <= sel_bit(y_q[15:0], idx_q);
                        res_q.id    <= id_q;
                    end else begin
                        y_q   <= y_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_o       = res_q.y;
    assign shift_o   = res_q.shift;
    assign ytp_o     = res_q.ytp;
    assign done_id_o = res_q.id;

endmodule

// File: tb/tb_norm_sched.sv
// Self-checking bench for norm_sched: vector table of single jobs, arbitration order, reset abort.
// Latency checked per job against grant cycle + 2 + shifts.
// Expected results are queued at grant time and consumed on done_o.
module tb_norm_sched;

    localparam int N = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_i;
    logic [N*32-1:0] data_i;
    logic [N*4-1:0]  index_i;
    logic [N-1:0]  gnt_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    done_id_o;
    logic [15:0]   y_o;
    logic [5:0]    shift_o;
    logic          ytp_o;

    norm_sched dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .data_i    (data_i),
        .index_i   (index_i),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .done_id_o (done_id_o),
        .y_o       (y_o),
        .shift_o   (shift_o),
        .ytp_o     (ytp_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] y;
        logic [5:0]  sh;
        logic        ytp;
        logic [1:0]  id;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer: every done_o must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("y_o",       32'(y_o),       32'(e.y));
                chk("shift_o",   32'(shift_o),   32'(e.sh));
                chk("ytp_o",     32'(ytp_o),     32'(e.ytp));
                chk("done_id_o", 32'(done_id_o), 32'(e.id));
                chk("done_cyc",  32'(cyc),       32'(e.cyc));
            end
        end
    end

    task automatic wait_grant(output logic [N-1:0] g, output int gc);
        bit got;
        got = 0;
        g   = '0;
        gc  = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            if (gnt_o != '0) begin
                got = 1;
                g   = gnt_o;
                gc  = cyc;
            end
        end
        if (!got) chk("grant_timeout", 32'(gnt_o), 32'hFFFF_FFFF);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !busy_o) ok = 1;
        end
        if (!ok) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input logic [15:0] y, input int sh, input logic ytp, input int id, input int c);
        exp_t e;
        e.y = y; e.sh = 6'(sh); e.ytp = ytp; e.id = 2'(id); e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_job(input int r, input logic [31:0] d, input logic [3:0] ix,
                          input logic [15:0] ey, input int esh, input logic eytp);
        logic [N-1:0] g;
        int gc;
        data_i[r*32 +: 32] = d;
        index_i[r*4 +: 4]  = ix;
        req_i[r]           = 1'b1;
        wait_grant(g, gc);
        chk("gnt_single", 32'(g), 32'(1 << r));
        push_exp(ey, esh, eytp, r, gc + 2 + esh);
        @(posedge clk_i); #1;
        req_i[r] = 1'b0;
        drain();
    endtask

    typedef struct {
        int          r;
        logic [31:0] d;
        logic [3:0]  ix;
        logic [15:0] y;
        int          sh;
        logic        ytp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        int gc, prev_gc, dcnt;

        tbl[0] = '{0, 32'h0001_2345, 4'd0,  16'h48D1, 2,  1'b0};
        tbl[1] = '{2, 32'hFFFF_FFFF, 4'd9,  16'h7FFF, 17, 1'b1};
        tbl[2] = '{1, 32'h0000_7FFF, 4'd7,  16'h7FFF, 0,  1'b0};
        tbl[3] = '{3, 32'h0000_0000, 4'd3,  16'h0000, 0,  1'b0};
        tbl[4] = '{1, 32'h0000_C000, 4'd6,  16'h6000, 1,  1'b1};
        tbl[5] = '{0, 32'h8000_0000, 4'd15, 16'h4000, 17, 1'b1};
        tbl[6] = '{3, 32'h0001_AAAA, 4'd0,  16'h6AAA, 2,  1'b1};

        rst_i   = 1'b1;
        req_i   = '0;
        data_i  = '0;
        index_i = '0;
        #2;
        chk("rst_busy",    32'(busy_o),    32'd0);
        chk("rst_done",    32'(done_o),    32'd0);
        chk("rst_gnt",     32'(gnt_o),     32'd0);
        chk("rst_y",       32'(y_o),       32'd0);
        chk("rst_shift",   32'(shift_o),   32'd0);
        chk("rst_ytp",     32'(ytp_o),     32'd0);
        chk("rst_done_id", 32'(done_id_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++)
            do_job(tbl[i].r, tbl[i].d, tbl[i].ix, tbl[i].y, tbl[i].sh, tbl[i].ytp);

        // Reset in the middle of a 17-shift job: no completion, outputs cleared.
        data_i[2*32 +: 32] = 32'hFFFF_FFFF;
        index_i[2*4 +: 4]  = 4'd9;
        req_i[2] = 1'b1;
        wait_grant(g, gc);
        chk("abort_gnt", 32'(g), 32'h4);
        push_exp(16'h7FFF, 17, 1'b1, 2, gc + 19);
        @(posedge clk_i); #1;
        req_i[2] = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("busy_mid_shift", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        sb.delete();
        chk("abort_busy",    32'(busy_o),    32'd0);
        chk("abort_done",    32'(done_o),    32'd0);
        chk("abort_y",       32'(y_o),       32'd0);
        chk("abort_shift",   32'(shift_o),   32'd0);
        chk("abort_ytp",     32'(ytp_o),     32'd0);
        chk("abort_done_id", 32'(done_id_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (done_o) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        do_job(3, 32'h0001_2345, 4'd0, 16'h48D1, 2, 1'b0);

        // Several requesters held high: check grant order, spacing and done ids.
        data_i[0*32 +: 32] = 32'h0000_0002;
        data_i[1*32 +: 32] = 32'h0000_0001;
        data_i[2*32 +: 32] = 32'h0000_7FFE;
        data_i[3*32 +: 32] = 32'h0000_1234;
        index_i = '0;
        prev_gc = 0;
`ifdef NORM_SCHED_FIXPRIO_EN
        req_i = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            int r;
            r = (k < 3) ? 1 : 3;
            wait_grant(g, gc);
            chk("fix_gnt_order", 32'(g), 32'(1 << r));
            if (k > 0 && k < 3) chk("fix_gnt_spacing", 32'(gc - prev_gc), 32'd4);
            prev_gc = gc;
            push_exp((r == 1) ? 16'h0001 : 16'h1234, 0, 1'b0, r, gc + 2);
            if (k == 2) begin
                @(posedge clk_i); #1;
                req_i[1] = 1'b0;
            end
        end
`else
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int r;
            logic [15:0] ey;
            r = k % 4;
            case (r)
                0: ey = 16'h0002;
                1: ey = 16'h0001;
                2: ey = 16'h7FFE;
                default: ey = 16'h1234;
            endcase
            wait_grant(g, gc);
            chk("rr_gnt_order", 32'(g), 32'(1 << r));
            if (k > 0) chk("rr_gnt_spacing", 32'(gc - prev_gc), 32'd4);
            prev_gc = gc;
            push_exp(ey, 0, (r == 0 || r == 2) ? 1'b1 : 1'b0, r, gc + 2);
        end
`endif
        @(posedge clk_i); #1;
        req_i = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/norm_sched.md
Name: norm_sched

Overview:
Shared normalize-and-select engine with a request/grant front end.
- Several requesters submit a 32-bit word plus a 4-bit digit index.
- A round-robin arbiter picks one requester at a time.
- The FSM shifts the word right one bit per cycle until it is below LIMIT.
- Outputs are the 16-bit result, the shift count and the indexed selection bit (ytp), tagged with the requester id.
- Sits between the measurement front ends and the display/decimal path.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 32, input data width
OW, 16, output width
LIMIT, 16'h8000, normalization threshold; stop when value < LIMIT

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_i  in  N_REQ  request per requester; held until own gnt_o bit pulses
data_i  in  N_REQ*DW  packed data, requester r at [r*DW +: DW]
index_i  in  N_REQ*4  packed digit index, requester r at [r*4 +: 4]
gnt_o  out  N_REQ  one-hot grant pulse, 1 cycle, in LOAD
busy_o  out  1  high in any state except IDLE
done_o  out  1  1-cycle completion pulse
done_id_o  out  $clog2(N_REQ)  id of completed requester
y_o  out  OW  normalized value, low OW bits
shift_o  out  6  number of right shifts applied
ytp_o  out  1  selected bit of y_o

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, RR pointer=0.
  - All outputs 0, internal y/index/count 0.
  - Asserting rst_i mid-operation aborts the job: no done_o, and the request is not remembered.
- IDLE:
  - If any req_i bit is high, arbitrate: pick the first high bit searching from the pointer upward, wrapping mod N_REQ.
  - Latch the winner id and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - gnt_o[id]=1.
  - Capture data_i and index_i of the winner into y and idx. Clear the count.
  - Pointer := (id+1) mod N_REQ.
  - Go to SHIFT.
  - The requester must hold data through LOAD. Dropping req_i in LOAD is ignored; the job still runs.
- SHIFT:
  - If y < LIMIT (full DW compare), go to DONE.
  - Else y := y>>1, count := count+1, stay.
  - Maximum count is DW-15 (17 at DW=32). y=0 finishes with count 0.
- DONE (1 cycle):
  - done_o=1. done_id_o=id, y_o=y[OW-1:0], shift_o=count.
  - ytp_o = y_o[14] if idx>7, else y_o[2*idx+1].
  - Go to IDLE.
  - y_o, shift_o, ytp_o and done_id_o are registered and held until the next DONE.
- Latency: with a grant in cycle c and k shifts, done_o is in cycle c+2+k. A new grant comes no earlier than 2 cycles after DONE.
- Requests that arrive while busy_o is high wait. They are arbitrated only in IDLE.
- gnt_o is never asserted for a requester whose req_i was low in the IDLE decision cycle.

Optional Feature:
NORM_SCHED_FIXPRIO_EN:
- Defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined: round-robin as above.

Decomposition:
- Package norm_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE}
  - default LIMIT and width constants
  - function sel_bit(y, idx) implementing the ytp rule
- Sub-module norm_rr_arb: N_REQ request vector plus pointer in, one-hot winner and encoded id out. Combinational; the pointer register is owned by norm_sched.
- The FSM and shift datapath stay in norm_sched.

Test Plan:
- req_i[0]=1, data 0x00012345, index 0 -> gnt_o=0001, then 2 shifts; done_o at c+4, y_o=0x48D1, shift_o=2, ytp_o=0, done_id_o=0.
- req_i[2]=1, data 0xFFFFFFFF, index 9 -> shift_o=17, y_o=0x7FFF, ytp_o=1 (bit14), done at c+19.
- data 0x00007FFF, and separately data 0 -> shift_o=0, done_o at c+2, y_o=0x7FFF / 0x0000.
- All four req_i held high for 4 jobs -> grants 0,1,2,3 in order, then 0 again; done_id_o follows the same order.
- rst_i pulsed during SHIFT of a 17-shift job -> busy_o drops immediately, no done_o, outputs 0; the next request is granted normally.
- NORM_SCHED_FIXPRIO_EN defined, req_i[1] and req_i[3] held high -> every grant goes to 1; after req_i[1] drops, requester 3 is granted.
